// File: rtl/main_mem_responder.sv
// Memory-side responder: accepts one read/write request at a time, holds it for
// LATENCY cycles, then returns a single-cycle valid pulse with read data or write
// completion. Optional per-byte write enables under MAIN_MEM_RESPONDER_BYTE_WRITE_EN.
module main_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 3
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] mem_data_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
`ifdef MAIN_MEM_RESPONDER_BYTE_WRITE_EN
   input  logic [3:0]  mem_byte_en_in,
`endif
   output logic        mem_ready_out,
   output logic [31:0] mem_data_out,
   output logic        mem_valid_out,
   output logic        mem_error_out
);

   localparam int Depth = 2 ** ADDR_WIDTH;
   localparam logic [3:0] CntInit = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e                  state_q;
   logic [3:0]              cnt_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic                    write_q;
   logic                    err_q;
   logic [3:0]              be_q;

   logic [31:0]             mem [Depth];

   logic                    req;
   logic                    req_err;
   logic [ADDR_WIDTH-1:0]   req_idx;
   logic [ADDR_WIDTH-1:0]   rsp_idx;
   logic                    rsp_err;
   logic                    rsp_rd;
   logic [31:0]             rsp_data;

   // Request decode and the response word; in IDLE the response is built from the
   // live inputs (LATENCY=1), otherwise from the latched request.
   always_comb begin
      req     = mem_read_in | mem_write_in;
      req_idx = mem_addr_in[ADDR_WIDTH+1:2];
      req_err = (mem_addr_in[1:0] != 2'b00) ||
                ((mem_addr_in >> (ADDR_WIDTH + 2)) != 32'd0) ||
                (mem_read_in && mem_write_in);
      if (state_q == StIdle) begin
         rsp_idx = req_idx;
         rsp_err = req_err;
         rsp_rd  = mem_read_in & ~mem_write_in;
      end else begin
         rsp_idx = addr_q;
         rsp_err = err_q;
         rsp_rd  = ~write_q;
      end
      rsp_data = (rsp_rd && !rsp_err) ? mem[rsp_idx] : 32'd0;
   end

   // Control FSM with registered handshake outputs.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q       <= StIdle;
         cnt_q         <= 4'd0;
         addr_q        <= '0;
         wdata_q       <= 32'd0;
         write_q       <= 1'b0;
         err_q         <= 1'b0;
         be_q          <= 4'd0;
         mem_ready_out <= 1'b1;
         mem_valid_out <= 1'b0;
         mem_error_out <= 1'b0;
         mem_data_out  <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  addr_q        <= req_idx;
                  wdata_q       <= mem_data_in;
                  write_q       <= mem_write_in;
                  err_q         <= req_err;
`ifdef MAIN_MEM_RESPONDER_BYTE_WRITE_EN
                  be_q          <= mem_byte_en_in;
`else
                  be_q          <= 4'hF;
`endif
                  mem_ready_out <= 1'b0;
                  if (LATENCY == 1) begin
                     state_q       <= StResp;
                     mem_valid_out <= 1'b1;
                     mem_error_out <= rsp_err;
                     mem_data_out  <= rsp_data;
                  end else begin
                     state_q <= StWait;
                     cnt_q   <= CntInit;
                  end
               end
            end
            StWait: begin
               if (cnt_q == 4'd0) begin
                  state_q       <= StResp;
                  mem_valid_out <= 1'b1;
                  mem_error_out <= rsp_err;
                  mem_data_out  <= rsp_data;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StResp: begin
               state_q       <= StIdle;
               mem_ready_out <= 1'b1;
               mem_valid_out <= 1'b0;
               mem_error_out <= 1'b0;
               mem_data_out  <= 32'd0;
            end
            default: begin
               state_q       <= StIdle;
               mem_ready_out <= 1'b1;
               mem_valid_out <= 1'b0;
               mem_error_out <= 1'b0;
               mem_data_out  <= 32'd0;
            end
         endcase
      end
   end

   // Array write commits on the edge that leaves RESP; reset abandons it.
   always_ff @(posedge clock_in) begin
      if (!reset_in && state_q == StResp && write_q && !err_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule
